// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage driving the data RAM, aligning loads, holding LLbit and flagging AdEL/AdES.
// Define MEM_UNALIGNED_EN to add LWL/LWR/SWL/SWR; otherwise those ops act as no-ops with wb_wreg_o forced low.
module mem_access_stage #(
   parameter int ADDR_W    = 32,
   parameter bit LLBIT_RST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [3:0]        mem_op_i,
   input  logic [4:0]        waddr_i,
   input  logic              wreg_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       reg2_i,
   input  logic [31:0]       ram_data_i,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [3:0]        ram_sel_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_data_o,
   output logic [4:0]        wb_waddr_o,
   output logic              wb_wreg_o,
   output logic [31:0]       wb_wdata_o,
   output logic              excp_adel_o,
   output logic              excp_ades_o,
   output logic [ADDR_W-1:0] bad_vaddr_o,
   output logic              llbit_o
);
   localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5;
   localparam logic [3:0] OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8, OP_LL = 4'd9, OP_SC = 4'd10;
   localparam logic [3:0] OP_LWL = 4'd11, OP_LWR = 4'd12, OP_SWL = 4'd13, OP_SWR = 4'd14;
   logic [1:0]        k;
   logic              is_byte, is_half, is_word, unal_op, bad_op, is_load, is_store;
   logic              lwl, lwr, swl, swr, misal, sc_fail, access;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       lwl_v, lwr_v;
   logic [4:0]        waddr_d, waddr_q;
   logic              wreg_d, wreg_q, adel_d, adel_q, ades_d, ades_q, llbit_d, llbit_q;
   logic [31:0]       wdata_d, wdata_q;
   logic [ADDR_W-1:0] bva_d, bva_q;
   assign k       = mem_addr_i[1:0];
   assign is_byte = mem_op_i inside {OP_LB, OP_LBU, OP_SB};
   assign is_half = mem_op_i inside {OP_LH, OP_LHU, OP_SH};
   assign is_word = mem_op_i inside {OP_LW, OP_SW, OP_LL, OP_SC};
`ifdef MEM_UNALIGNED_EN
   assign unal_op = mem_op_i inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR};
   assign bad_op  = 1'b0;
`else
   assign unal_op = 1'b0;
   assign bad_op  = mem_op_i inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR};
`endif
   assign lwl      = unal_op & (mem_op_i == OP_LWL);
   assign lwr      = unal_op & (mem_op_i == OP_LWR);
   assign swl      = unal_op & (mem_op_i == OP_SWL);
   assign swr      = unal_op & (mem_op_i == OP_SWR);
   assign is_load  = (mem_op_i inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL}) | lwl | lwr;
   assign is_store = (mem_op_i inside {OP_SB, OP_SH, OP_SW, OP_SC}) | swl | swr;
   assign misal    = (is_half & k[0]) | (is_word & (k != 2'b00));
   assign sc_fail  = (mem_op_i == OP_SC) & ~llbit_q;
   // A failing SC performs no RAM access at all
   assign access     = (is_byte | is_half | is_word | unal_op) & ~misal & ~sc_fail;
   assign ram_ce_o   = access;
   assign ram_we_o   = access & is_store & ~stall & ~flush;
   assign ram_addr_o = {mem_addr_i[ADDR_W-1:2], 2'b00};
   assign ram_sel_o  = is_byte ? 4'b1000 >> k :
                       is_half ? (k[1] ? 4'b0011 : 4'b1100) :
                       swl     ? 4'b1111 >> k :
                       swr     ? 4'b1111 << ~k : 4'b1111;
   assign ram_data_o = is_byte ? {4{reg2_i[7:0]}} :
                       is_half ? {2{reg2_i[15:0]}} :
                       swl     ? reg2_i >> {k, 3'b000} :
                       swr     ? reg2_i << {~k, 3'b000} : reg2_i;
   assign byte_v = 8'(ram_data_i >> {~k, 3'b000});
   assign half_v = k[1] ? ram_data_i[15:0] : ram_data_i[31:16];
   assign lwl_v  = (ram_data_i << {k, 3'b000}) | (reg2_i & ~(32'hFFFF_FFFF << {k, 3'b000}));
   assign lwr_v  = (ram_data_i >> {~k, 3'b000}) | (reg2_i & ~(32'hFFFF_FFFF >> {~k, 3'b000}));
   assign wdata_d = misal                  ? 32'h0 :
                    mem_op_i == OP_LB      ? {{24{byte_v[7]}}, byte_v} :
                    mem_op_i == OP_LBU     ? {24'h0, byte_v} :
                    mem_op_i == OP_LH      ? {{16{half_v[15]}}, half_v} :
                    mem_op_i == OP_LHU     ? {16'h0, half_v} :
                    mem_op_i inside {OP_LW, OP_LL} ? ram_data_i :
                    mem_op_i == OP_SC      ? {31'h0, llbit_q} :
                    lwl                    ? lwl_v :
                    lwr                    ? lwr_v : wdata_i;
   assign waddr_d = waddr_i;
   assign wreg_d  = (misal | bad_op) ? 1'b0 : (mem_op_i == OP_SC) ? 1'b1 : wreg_i;
   assign adel_d  = misal & is_load;
   assign ades_d  = misal & is_store;
   assign bva_d   = misal ? mem_addr_i : '0;
   assign llbit_d = flush                               ? 1'b0 :
                    stall                               ? llbit_q :
                    (mem_op_i == OP_LL) & ~misal        ? 1'b1 :
                    (mem_op_i == OP_SC) & ~misal        ? 1'b0 : llbit_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         waddr_q <= '0;
         wreg_q  <= 1'b0;
         wdata_q <= '0;
         adel_q  <= 1'b0;
         ades_q  <= 1'b0;
         bva_q   <= '0;
         llbit_q <= LLBIT_RST;
      end else begin
         llbit_q <= llbit_d;
         if (flush) begin
            waddr_q <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
            bva_q   <= '0;
         end else if (!stall) begin
            waddr_q <= waddr_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            adel_q  <= adel_d;
            ades_q  <= ades_d;
            bva_q   <= bva_d;
         end
      end
   end
   assign wb_waddr_o  = waddr_q;
   assign wb_wreg_o   = wreg_q;
   assign wb_wdata_o  = wdata_q;
   assign excp_adel_o = adel_q;
   assign excp_ades_o = ades_q;
   assign bad_vaddr_o = bva_q;
   assign llbit_o     = llbit_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed stimulus against a byte-lane reference model with a queue scoreboard.
module tb_mem_access_stage;
`ifdef MEM_UNALIGNED_EN
   localparam bit UNAL = 1'b1;
`else
   localparam bit UNAL = 1'b0;
`endif
   logic        clk = 1'b1;
   logic        rst, stall, flush, wreg_i;
   logic [3:0]  mem_op_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i, mem_addr_i, reg2_i, ram_data_i;
   logic        ram_ce_o, ram_we_o, wb_wreg_o, excp_adel_o, excp_ades_o, llbit_o;
   logic [3:0]  ram_sel_o;
   logic [31:0] ram_addr_o, ram_data_o, wb_wdata_o, bad_vaddr_o;
   logic [4:0]  wb_waddr_o;

   mem_access_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_op_i(mem_op_i), .waddr_i(waddr_i),
      .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .ram_data_i(ram_data_i),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
      .ram_data_o(ram_data_o), .wb_waddr_o(wb_waddr_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
      .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o), .bad_vaddr_o(bad_vaddr_o), .llbit_o(llbit_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        ce, we, is_st, wreg, adel, ades, ll;
      bit [3:0]  sel;
      bit [4:0]  waddr;
      bit [31:0] addr, dout, wdata, bva;
   } exp_t;
   exp_t q[$];
   int n_tests = 0, n_fail = 0;
   bit        m_ll = 1'b0, m_wreg = 1'b0, m_adel = 1'b0, m_ades = 1'b0;
   bit [4:0]  m_waddr = '0;
   bit [31:0] m_wdata = '0, m_bva = '0;

   function automatic bit [7:0] byte_at(input bit [31:0] x, input int j);
      return 8'(x >> (8 * (3 - j)));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input bit [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic issue(input bit [3:0] op, input bit [31:0] addr, input bit [31:0] reg2, input bit [31:0] ram,
                        input bit st = 0, input bit fl = 0, input bit r = 0,
                        input bit [31:0] wd = 32'h5A5A_0F0F, input bit [4:0] wa = 5'd7, input bit wr = 1'b1);
      int k, sz;
      bit ld, sto, un, mis, on;
      bit [31:0] res;
      bit [7:0] b;
      exp_t e;
      @(negedge clk);
      rst = r; stall = st; flush = fl; mem_op_i = op; mem_addr_i = addr; reg2_i = reg2;
      ram_data_i = ram; wdata_i = wd; waddr_i = wa; wreg_i = wr;
      k = int'(addr[1:0]); sz = 0; ld = 0; sto = 0; un = 0;
      case (op)
         1, 2:   begin sz = 1; ld = 1; end
         3, 4:   begin sz = 2; ld = 1; end
         5, 9:   begin sz = 4; ld = 1; end
         6:      begin sz = 1; sto = 1; end
         7:      begin sz = 2; sto = 1; end
         8, 10:  begin sz = 4; sto = 1; end
         11, 12: begin un = UNAL; ld = UNAL; end
         13, 14: begin un = UNAL; sto = UNAL; end
         default: ;
      endcase
      mis = sz > 1 && (addr % sz) != 0;
      e.ce = (sz != 0 || un) && !mis && !(op == 10 && !m_ll);
      e.we = e.ce && sto && !st && !fl;
      e.is_st = sto;
      e.addr = addr & ~32'h3;
      e.sel = '0; e.dout = '0;
      for (int j = 0; j < 4; j++) begin
         on = (un && op == 13) ? j >= k : (un && op == 14) ? j <= k : sz != 0 ? (j >= k && j < k + sz) : 1'b1;
         b = (un && op == 13) ? (on ? byte_at(reg2, j - k) : 8'h0) :
             (un && op == 14) ? (on ? byte_at(reg2, 3 - k + j) : 8'h0) :
             sz != 0 ? byte_at(reg2, 4 - sz + j % sz) : byte_at(reg2, j);
         e.sel[3 - j] = on;
         e.dout[31 - 8 * j -: 8] = b;
      end
      res = wd;
      case (op)
         1, 2: begin res = byte_at(ram, k); if (op == 1 && res >= 128) res -= 256; end
         3, 4: begin res = byte_at(ram, k) * 256 + byte_at(ram, k + 1); if (op == 3 && res >= 32768) res -= 65536; end
         5, 9: res = ram;
         10:   res = m_ll;
         11:   if (UNAL) for (int j = 0; j < 4; j++) res[31 - 8 * j -: 8] = (j + k <= 3) ? byte_at(ram, j + k) : byte_at(reg2, j);
         12:   if (UNAL) for (int j = 0; j < 4; j++) res[31 - 8 * j -: 8] = (j >= 3 - k) ? byte_at(ram, j - 3 + k) : byte_at(reg2, j);
         default: ;
      endcase
      if (mis) res = 0;
      if (r || fl) begin
         m_waddr = 0; m_wreg = 0; m_wdata = 0; m_adel = 0; m_ades = 0; m_bva = 0; m_ll = 0;
      end else if (!st) begin
         m_waddr = wa;
         m_wreg = mis ? 1'b0 : (op >= 11 && op <= 14 && !UNAL) ? 1'b0 : (op == 10) ? 1'b1 : wr;
         m_wdata = res;
         m_adel = mis && ld;
         m_ades = mis && sto;
         m_bva = mis ? addr : 32'h0;
         if (op == 9 && !mis) m_ll = 1;
         else if (op == 10 && !mis) m_ll = 0;
      end
      e.waddr = m_waddr; e.wreg = m_wreg; e.wdata = m_wdata; e.adel = m_adel;
      e.ades = m_ades; e.bva = m_bva; e.ll = m_ll;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ram_ce", ram_ce_o, e.ce);
            chk("ram_we", ram_we_o, e.we);
            chk("ram_addr", ram_addr_o, e.addr);
            if (e.ce) chk("ram_sel", ram_sel_o, e.sel);
            if (e.ce && e.is_st) chk("ram_data", ram_data_o, e.dout);
            @(posedge clk);
            #1;
            chk("wb_waddr", wb_waddr_o, e.waddr);
            chk("wb_wreg", wb_wreg_o, e.wreg);
            chk("wb_wdata", wb_wdata_o, e.wdata);
            chk("excp_adel", excp_adel_o, e.adel);
            chk("excp_ades", excp_ades_o, e.ades);
            chk("bad_vaddr", bad_vaddr_o, e.bva);
            chk("llbit", llbit_o, e.ll);
         end
      end
   end

   initial begin : driver
      bit [31:0] a;
      issue(0, 0, 0, 0, 0, 0, 1);
      issue(0, 0, 0, 0, 0, 0, 1);
      issue(6, 32'h101, 32'hAB, 32'h0);
      issue(1, 32'h101, 32'h0, 32'h00AB_0000);
      issue(2, 32'h101, 32'h0, 32'h00AB_0000);
      issue(3, 32'h3, 32'h0, 32'h1234_5678);
      issue(8, 32'h2, 32'h1111_2222, 32'h0);
      issue(4, 32'h102, 32'h0, 32'h1234_8765);
      issue(3, 32'h100, 32'h0, 32'h8765_1234);
      issue(9, 32'h100, 32'h0, 32'hCAFE_F00D);
      issue(10, 32'h100, 32'h1234, 32'h0);
      issue(10, 32'h100, 32'h1234, 32'h0);
      issue(9, 32'h100, 32'h0, 32'h0);
      issue(0, 32'h0, 32'h0, 32'h0, 0, 1);
      issue(10, 32'h100, 32'h5678, 32'h0);
      issue(9, 32'h104, 32'h0, 32'hDEAD_BEEF);
      issue(9, 32'h108, 32'h0, 32'h1, 1, 1);
      issue(5, 32'h10, 32'h0, 32'h0BAD_F00D);
      for (int i = 0; i < 3; i++) issue(8, 32'h200, 32'h9999_8888, 32'h0, 1);
      issue(8, 32'h200, 32'h9999_8888, 32'h0);
      issue(11, 32'h1, 32'hAABB_CCDD, 32'h1122_3344);
      issue(14, 32'h1, 32'hAABB_CCDD, 32'h0);
      issue(12, 32'h2, 32'hAABB_CCDD, 32'h1122_3344);
      issue(13, 32'h3, 32'hAABB_CCDD, 32'h0);
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         issue(4'($urandom_range(0, 15)), a, $urandom, $urandom, $urandom_range(0, 4) == 0,
               $urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0, $urandom, 5'($urandom), 1'($urandom));
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
